// File: rtl/commit_trace_pkg.sv
// rtl/commit_trace_pkg.sv - shared record type and width helpers for the commit trace buffer
// Purpose: defines the trace record layout (pc, instr, daddr, data, rw) and its width.
// Contents: TRACE_DW, trace_rec_t, TRACE_REC_W, rec_width().
package commit_trace_pkg;

    localparam int TRACE_DW = 32;

    typedef struct packed {
        logic [TRACE_DW-1:0] pc;
        logic [TRACE_DW-1:0] instr;
        logic [TRACE_DW-1:0] daddr;
        logic [TRACE_DW-1:0] data;
        logic                rw;
    } trace_rec_t;

    localparam int TRACE_REC_W = $bits(trace_rec_t);

    // Flat record width for an arbitrary field width, same field order as trace_rec_t.
    function automatic int rec_width(input int dw);
        return 4 * dw + 1;
    endfunction

endpackage

// File: rtl/trace_fifo_mem.sv
// rtl/trace_fifo_mem.sv - simple dual-port register array for trace records
// Purpose: DEPTH x WIDTH storage, synchronous write, combinational read.
// Ports: i_clk clock; i_we/i_waddr/i_wdata write port; i_raddr/o_rdata read port.
module trace_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 129
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    // No reset: contents are meaningless until written, and the top gates outputs.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - first-word-fall-through capture FIFO of retired-instruction trace records
// Purpose: records one trace record per commit, drains via valid/ready, counts dropped commits.
// Ports: CLK/RESET clock and async active-high reset; enable/clear capture control;
//        commit_valid + iaddr/idata/daddr/ddata_w/ddata_r/d_rw commit inputs;
//        trace_valid/trace_ready + trace_pc/instr/daddr/data/rw head record;
//        count occupancy, almost_full flag, overflow_cnt saturating drop counter.
module commit_trace_buffer
    import commit_trace_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AF_MARGIN  = 2,
    parameter int OVF_WIDTH  = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    enable,
    input  logic                    clear,
    input  logic                    commit_valid,
    input  logic [DATA_WIDTH-1:0]   iaddr,
    input  logic [DATA_WIDTH-1:0]   idata,
    input  logic [DATA_WIDTH-1:0]   daddr,
    input  logic [DATA_WIDTH-1:0]   ddata_w,
    input  logic [DATA_WIDTH-1:0]   ddata_r,
    input  logic                    d_rw,
    output logic                    trace_valid,
    input  logic                    trace_ready,
    output logic [DATA_WIDTH-1:0]   trace_pc,
    output logic [DATA_WIDTH-1:0]   trace_instr,
    output logic [DATA_WIDTH-1:0]   trace_daddr,
    output logic [DATA_WIDTH-1:0]   trace_data,
    output logic                    trace_rw,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    almost_full,
    output logic [OVF_WIDTH-1:0]    overflow_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = rec_width(DATA_WIDTH);

    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_W-1:0]     r_count;
    logic [OVF_WIDTH-1:0] r_ovf;

    logic             w_full;
    logic             w_valid;
    logic             w_commit;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic [REC_W-1:0] w_wrec;
    logic [REC_W-1:0] w_rrec;

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_valid  = (r_count != '0);
    assign w_pop    = w_valid & trace_ready & ~clear;
    assign w_commit = commit_valid & enable & ~clear;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push   = w_commit & (~w_full | w_pop);
    assign w_drop   = w_commit & w_full & ~w_pop;

    assign w_wrec = {iaddr, idata, daddr, (d_rw ? ddata_w : ddata_r), d_rw};

    trace_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_mem (
        .i_clk   (CLK),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata (w_wrec),
        .i_raddr (r_rptr),
        .o_rdata (w_rrec)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= '0;
        end else if (clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_ovf != '1)) begin
                r_ovf <= r_ovf + 1'b1;
            end
        end
    end

    // Head fields are forced to zero while empty so that the post-reset outputs
    // are defined even though storage is never reset.
    assign trace_valid  = w_valid;
    assign trace_pc     = w_valid ? w_rrec[4*DATA_WIDTH:3*DATA_WIDTH+1] : '0;
    assign trace_instr  = w_valid ? w_rrec[3*DATA_WIDTH:2*DATA_WIDTH+1] : '0;
    assign trace_daddr  = w_valid ? w_rrec[2*DATA_WIDTH:DATA_WIDTH+1]   : '0;
    assign trace_data   = w_valid ? w_rrec[DATA_WIDTH:1]                : '0;
    assign trace_rw     = w_valid ? w_rrec[0]                           : 1'b0;
    assign count        = r_count;
    assign almost_full  = (r_count >= CNT_W'(DEPTH - AF_MARGIN));
    assign overflow_cnt = r_ovf;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb/tb_commit_trace_buffer.sv - self-checking scoreboard bench for commit_trace_buffer
module tb_commit_trace_buffer;
    import commit_trace_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AFM   = 2;
    localparam int OVW   = 4;
    localparam int OVMAX = (1 << OVW) - 1;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic          commit_valid = 1'b0;
    logic [DW-1:0] iaddr = '0;
    logic [DW-1:0] idata = '0;
    logic [DW-1:0] daddr = '0;
    logic [DW-1:0] ddata_w = '0;
    logic [DW-1:0] ddata_r = '0;
    logic          d_rw = 1'b0;
    logic          trace_valid;
    logic          trace_ready = 1'b0;
    logic [DW-1:0] trace_pc;
    logic [DW-1:0] trace_instr;
    logic [DW-1:0] trace_daddr;
    logic [DW-1:0] trace_data;
    logic          trace_rw;
    logic [4:0]    count;
    logic          almost_full;
    logic [OVW-1:0] overflow_cnt;

    commit_trace_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_MARGIN  (AFM),
        .OVF_WIDTH  (OVW)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .enable       (enable),
        .clear        (clear),
        .commit_valid (commit_valid),
        .iaddr        (iaddr),
        .idata        (idata),
        .daddr        (daddr),
        .ddata_w      (ddata_w),
        .ddata_r      (ddata_r),
        .d_rw         (d_rw),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_pc     (trace_pc),
        .trace_instr  (trace_instr),
        .trace_daddr  (trace_daddr),
        .trace_data   (trace_data),
        .trace_rw     (trace_rw),
        .count        (count),
        .almost_full  (almost_full),
        .overflow_cnt (overflow_cnt)
    );

    always #5 CLK = ~CLK;

    trace_rec_t exp_q[$];
    int         exp_ovf = 0;
    int         n_assert = 0;
    int         n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_head();
        if (exp_q.size() > 0) begin
            chk("head_valid", 64'(trace_valid), 64'(1));
            chk("head_pc",    64'(trace_pc),    64'(exp_q[0].pc));
            chk("head_instr", 64'(trace_instr), 64'(exp_q[0].instr));
            chk("head_daddr", 64'(trace_daddr), 64'(exp_q[0].daddr));
            chk("head_data",  64'(trace_data),  64'(exp_q[0].data));
            chk("head_rw",    64'(trace_rw),    64'(exp_q[0].rw));
        end
    endtask

    task automatic check_state();
        chk("count",        64'(count),        64'(exp_q.size()));
        chk("trace_valid",  64'(trace_valid),  64'(exp_q.size() != 0));
        chk("almost_full",  64'(almost_full),  64'(exp_q.size() >= DEPTH - AFM));
        chk("overflow_cnt", 64'(overflow_cnt), 64'(exp_ovf));
    endtask

    // Called at a falling edge: drive inputs, check the head, predict the
    // rising-edge effect, then check state at the next falling edge.
    task automatic cyc(input logic cv, input logic en, input logic clr, input logic rdy,
                       input logic [DW-1:0] ia, input logic [DW-1:0] id,
                       input logic [DW-1:0] da, input logic [DW-1:0] dwd,
                       input logic [DW-1:0] drd, input logic rw);
        trace_rec_t r;
        bit full, pop, cmt, push;
        commit_valid = cv; enable = en; clear = clr; trace_ready = rdy;
        iaddr = ia; idata = id; daddr = da; ddata_w = dwd; ddata_r = drd; d_rw = rw;
        check_head();
        full = (exp_q.size() == DEPTH);
        pop  = (exp_q.size() != 0) && rdy && !clr;
        cmt  = cv && en && !clr;
        push = cmt && (!full || pop);
        if (clr) begin
            exp_q.delete();
            exp_ovf = 0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (push) begin
                r.pc = ia; r.instr = id; r.daddr = da; r.rw = rw;
                r.data = rw ? dwd : drd;
                exp_q.push_back(r);
            end else if (cmt && exp_ovf < OVMAX) begin
                exp_ovf++;
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        commit_valid = 1'b0;
        clear = 1'b0;
        check_state();
    endtask

    task automatic commit(input logic [DW-1:0] ia, input logic rdy);
        cyc(1'b1, 1'b1, 1'b0, rdy, ia, 32'h1300_0000 | ia, 32'h2000 + ia,
            ~ia, 32'h5500 + ia, ia[2]);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 1'b1, 1'b0, rdy, '0, '0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        // Reset state
        @(negedge CLK);
        @(negedge CLK);
        check_state();
        chk("rst_pc",   64'(trace_pc),   64'(0));
        chk("rst_data", 64'(trace_data), 64'(0));
        chk("rst_rw",   64'(trace_rw),   64'(0));
        RESET = 1'b0;

        // Three loads with consumer stalled, head must hold
        cyc(1, 1, 0, 0, 32'h00, 32'hA0, 32'h0, 32'hF0, 32'h11, 0);
        cyc(1, 1, 0, 0, 32'h04, 32'hA4, 32'h0, 32'hF4, 32'h22, 0);
        cyc(1, 1, 0, 0, 32'h08, 32'hA8, 32'h0, 32'hF8, 32'h33, 0);
        chk("t1_count", 64'(count),    64'(3));
        chk("t1_pc",    64'(trace_pc), 64'(0));
        chk("t1_data",  64'(trace_data), 64'(32'h11));
        idle(0);
        idle(0);

        // Store record, then drain everything
        cyc(1, 1, 0, 0, 32'h10, 32'hB0, 32'h100, 32'hDEADBEEF, 32'h5, 1);
        for (int i = 0; i < 4; i++) idle(1);
        chk("t2_empty", 64'(trace_valid), 64'(0));

        // enable=0 ignores commits without counting drops
        cyc(1, 0, 0, 0, 32'h77, 32'h0, 32'h0, 32'h0, 32'h0, 0);

        // Fill to 16, then 4 drops
        for (int i = 0; i < 16; i++) commit(32'(i * 4), 0);
        for (int i = 0; i < 4; i++) commit(32'h40 + 32'(i * 4), 0);
        chk("t3_ovf", 64'(overflow_cnt), 64'(4));

        // Full with simultaneous push/pop across pointer wrap
        for (int i = 0; i < 20; i++) commit(32'h100 + 32'(i * 4), 1);
        chk("t4_count", 64'(count), 64'(16));
        for (int i = 0; i < 16; i++) idle(1);

        // Saturation after a clean clear
        cyc(0, 1, 1, 0, '0, '0, '0, '0, '0, 0);
        for (int i = 0; i < 16; i++) commit(32'h200 + 32'(i * 4), 0);
        for (int i = 0; i < 18; i++) commit(32'h300 + 32'(i * 4), 0);
        chk("t5_sat", 64'(overflow_cnt), 64'(OVMAX));
        // clear with a same-cycle commit discards it
        cyc(1, 1, 1, 1, 32'h400, 32'h1, 32'h2, 32'h3, 32'h4, 1);
        chk("t5_clr_count", 64'(count), 64'(0));
        chk("t5_clr_ovf",   64'(overflow_cnt), 64'(0));

        // Asynchronous reset mid-cycle with 5 records held
        for (int i = 0; i < 5; i++) commit(32'h500 + 32'(i * 4), 0);
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        chk("arst_count", 64'(count),       64'(0));
        chk("arst_valid", 64'(trace_valid), 64'(0));
        chk("arst_pc",    64'(trace_pc),    64'(0));
        exp_q.delete();
        exp_ovf = 0;
        @(negedge CLK);
        RESET = 1'b0;
        commit(32'h600, 0);
        chk("arst_first", 64'(trace_pc), 64'(32'h600));
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
